// File: rtl/msg_sched_ctrl_pkg.sv
// Shared widths, block geometry, FSM encoding and tag layout for the
// SHA-256 message-schedule sequencer.
package msg_sched_ctrl_pkg;
   localparam int BEAT_W          = 64;
   localparam int WORD_W          = 32;
   localparam int BEATS_PER_BLOCK = 8;
   localparam int BEATS_TOTAL     = 32;
   localparam int IDX_W           = $clog2(BEATS_TOTAL);
   localparam int PTR_W           = $clog2(BEATS_PER_BLOCK);

   typedef logic [BEAT_W-1:0] beat_t;

   // One beat carries a W pair: low word is the even round, high word the odd one.
   typedef struct packed {
      logic [WORD_W-1:0] w_odd;
      logic [WORD_W-1:0] w_even;
   } wpair_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } tag_t;
endpackage

// File: rtl/msg_sched_ctrl_if.sv
// Message source, compression-core and datapath signals of the sequencer.
interface msg_sched_ctrl_if;
   import msg_sched_ctrl_pkg::*;

   logic             clear_i;
   logic             msg_valid_i;
   wpair_t           msg_data_i;
   logic             msg_ready_o;
   logic             core_ready_i;
   wpair_t           fb_data_i;
   wpair_t           pre_data_o;
   logic             sel_feedback_o;
   logic             round_valid_o;
   logic [IDX_W-1:0] round_idx_o;
   logic             block_start_o;
   logic             block_done_o;
   logic             busy_o;

   modport master (
      output clear_i, msg_valid_i, msg_data_i, core_ready_i, fb_data_i,
      input  msg_ready_o, pre_data_o, sel_feedback_o, round_valid_o,
             round_idx_o, block_start_o, block_done_o, busy_o
   );

   modport slave (
      input  clear_i, msg_valid_i, msg_data_i, core_ready_i, fb_data_i,
      output msg_ready_o, pre_data_o, sel_feedback_o, round_valid_o,
             round_idx_o, block_start_o, block_done_o, busy_o
   );
endinterface

// File: rtl/msg_sched_ctrl_msg_buf8.sv
// Eight-beat message fill buffer: write pointer, full flag, combinational read.
// Stays full until the sequencer frees it; beats offered while full are refused.
module msg_buf8
   import msg_sched_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear,
   input  logic             wr_vld,
   input  beat_t            wr_dat,
   output logic             wr_rdy,
   input  logic             free,
   input  logic [PTR_W-1:0] rd_idx,
   output beat_t            rd_dat,
   output logic             full
);
   beat_t            mem [BEATS_PER_BLOCK];
   logic [PTR_W-1:0] wr_cnt;
   logic             wr_en;

   assign wr_rdy = !full;
   assign wr_en  = wr_vld && wr_rdy && !clear;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_cnt <= '0;
         full   <= 1'b0;
      end else if (clear) begin
         wr_cnt <= '0;
         full   <= 1'b0;
      end else if (wr_en) begin
         wr_cnt <= wr_cnt + 1'b1;
         if (wr_cnt == PTR_W'(BEATS_PER_BLOCK - 1))
            full <= 1'b1;
      end else if (free) begin
         full <= 1'b0;
      end
   end

   // Storage needs no reset: it is only read while full, i.e. after eight fresh writes.
   always_ff @(posedge clk_i) begin
      if (wr_en)
         mem[wr_cnt] <= wr_dat;
   end

   assign rd_dat = mem[rd_idx];
endmodule

// File: rtl/msg_sched_ctrl.sv
// SHA-256 message-schedule sequencer: buffers a block, streams 8 message + 24
// feedback beats, and tags the datapath output PIPE_LAT cycles later.
module msg_sched_ctrl
   import msg_sched_ctrl_pkg::*;
#(
   parameter int PIPE_LAT = 2
)(
   input  logic             clk_i,
   input  logic             rst_ni,
   msg_sched_ctrl_if.slave  bus
);
   state_t           state, nxt_state;
   logic [IDX_W-1:0] beat_cnt;
   logic [2:0]       drain_cnt;
   logic             buf_full, buf_rdy, buf_free;
   beat_t            buf_rd;
   logic             last_beat, last_drain, launch, msg_phase;
   tag_t             cur_tag;
   tag_t             tag_pipe [PIPE_LAT];

   msg_buf8 u_buf (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear  (bus.clear_i),
      .wr_vld (bus.msg_valid_i),
      .wr_dat (bus.msg_data_i),
      .wr_rdy (buf_rdy),
      .free   (buf_free),
      .rd_idx (beat_cnt[PTR_W-1:0]),
      .rd_dat (buf_rd),
      .full   (buf_full)
   );

   assign bus.msg_ready_o = buf_rdy;

   assign last_beat  = (state == ST_STREAM) && (beat_cnt == IDX_W'(BEATS_TOTAL - 1));
   assign last_drain = (state == ST_DRAIN) && (drain_cnt == 3'(PIPE_LAT - 1));
   assign launch     = buf_full && bus.core_ready_i;
   assign msg_phase  = beat_cnt < IDX_W'(BEATS_PER_BLOCK);
   // The last message beat is read this cycle, so the buffer may refill from the next one.
   assign buf_free   = (state == ST_STREAM) && (beat_cnt == IDX_W'(BEATS_PER_BLOCK - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         state <= ST_IDLE;
      else
         state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      if (bus.clear_i) begin
         nxt_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (launch) nxt_state = ST_STREAM;
            ST_STREAM: if (last_beat) nxt_state = ST_DRAIN;
            ST_DRAIN:  if (last_drain) nxt_state = launch ? ST_STREAM : ST_IDLE;
            default:   nxt_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.pre_data_o     = '0;
      bus.sel_feedback_o = 1'b0;
      bus.block_start_o  = 1'b0;
      bus.busy_o         = (state != ST_IDLE);
      if (state == ST_STREAM) begin
         bus.block_start_o = (beat_cnt == '0);
         if (msg_phase) begin
            bus.pre_data_o = buf_rd;
         end else begin
            bus.pre_data_o     = bus.fb_data_i;
            bus.sel_feedback_o = 1'b1;
         end
      end
   end

   // beat_cnt wraps 31 -> 0 on its own, leaving it at 0 for the next block.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else if (bus.clear_i) begin
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (state == ST_STREAM)
            beat_cnt <= beat_cnt + 1'b1;
         if (state == ST_DRAIN && !last_drain)
            drain_cnt <= drain_cnt + 1'b1;
         else
            drain_cnt <= '0;
      end
   end

   assign cur_tag.vld = (state == ST_STREAM);
   assign cur_tag.idx = beat_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= '0;
      end else if (bus.clear_i) begin
         for (int i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         tag_pipe[0] <= cur_tag;
         for (int i = 1; i < PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   assign bus.round_valid_o = tag_pipe[PIPE_LAT-1].vld;
   assign bus.round_idx_o   = tag_pipe[PIPE_LAT-1].idx;
   assign bus.block_done_o  = bus.round_valid_o && (bus.round_idx_o == IDX_W'(BEATS_TOTAL - 1));
endmodule

// File: tb/tb_msg_sched_ctrl.sv
// Bench for msg_sched_ctrl: a time-since-block-start model checked every cycle,
// plus directed scenarios with hand-computed cycle distances and beat values.
module tb_msg_sched_ctrl;
   import msg_sched_ctrl_pkg::*;

   localparam int PL     = 2;
   localparam int T_IDLE = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   msg_sched_ctrl_if bus ();

   msg_sched_ctrl #(.PIPE_LAT(PL)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: buffered beats as a queue, plus m_t = cycles since the current block started.
   logic [63:0] m_q [$];
   logic [63:0] m_blk [8];
   int          m_t = T_IDLE;
   int          last_acc_cyc = 0;
   bit          m_start;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_t = T_IDLE;
      end else if (bus.clear_i) begin
         m_q.delete();
         m_t = T_IDLE;
      end else begin
         m_start = (m_q.size() == 8) && bus.core_ready_i && (m_t >= 31 + PL);
         if (m_t == 7) begin
            m_q.delete();
         end else if (bus.msg_valid_i && m_q.size() < 8) begin
            m_q.push_back(bus.msg_data_i);
            last_acc_cyc = cyc;
         end
         if (m_start) begin
            for (int i = 0; i < 8; i++) m_blk[i] = m_q[i];
            m_t = 0;
         end else if (m_t < T_IDLE) begin
            m_t++;
         end
      end
   end

   logic [63:0] cap [8];
   int fb_rise = -1;
   int rv_run = 0, last_rv_run = 0, low_run = 0, last_gap = 0;
   int start_q [$];
   int done_q  [$];

   always @(negedge clk) begin
      if (rst_n) begin
         logic [63:0] e_pre;
         int rel;
         if (m_t < 8)       e_pre = m_blk[m_t];
         else if (m_t < 32) e_pre = bus.fb_data_i;
         else               e_pre = 64'h0;
         chk("pre_data", bus.pre_data_o, e_pre);
         chk("sel_feedback", bus.sel_feedback_o, m_t >= 8 && m_t < 32);
         chk("round_valid", bus.round_valid_o, m_t >= PL && m_t < 32 + PL);
         if (m_t >= PL && m_t < 32 + PL)
            chk("round_idx", bus.round_idx_o, m_t - PL);
         chk("block_start", bus.block_start_o, m_t == 0);
         chk("block_done", bus.block_done_o, m_t == 31 + PL);
         chk("busy", bus.busy_o, m_t < 32 + PL);
         chk("msg_ready", bus.msg_ready_o, m_q.size() < 8);

         if (bus.block_start_o) begin
            start_q.push_back(cyc);
            fb_rise = -1;
         end
         if (start_q.size() > 0) begin
            rel = cyc - start_q[$];
            if (rel >= 0 && rel < 8) cap[rel] = bus.pre_data_o;
            if (bus.sel_feedback_o && fb_rise < 0) fb_rise = rel;
         end
         if (bus.block_done_o) done_q.push_back(cyc);
         if (bus.round_valid_o) begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
            rv_run++;
         end else begin
            if (rv_run > 0) last_rv_run = rv_run;
            rv_run = 0;
            low_run++;
         end
      end
   end

   initial begin
      bus.fb_data_i = '0;
      forever begin
         @(posedge clk);
         #2 bus.fb_data_i = {$urandom, $urandom};
      end
   end

   task automatic fill(input logic [63:0] base, input int gap);
      for (int i = 0; i < 8; i++) begin
         int tries;
         bit acc;
         tries = 0;
         acc = 1'b0;
         while (!acc && tries < 200) begin
            bus.msg_valid_i = 1'b1;
            bus.msg_data_i  = base + 64'(i);
            @(negedge clk);
            acc = bus.msg_ready_o;
            @(posedge clk);
            #1 bus.msg_valid_i = 1'b0;
            tries++;
            repeat (gap) begin
               @(posedge clk);
               #1;
            end
         end
         chk("fill_accept", acc, 1'b1);
      end
   endtask

   task automatic wait_done(input int n, input string name);
      int k;
      k = 0;
      while (done_q.size() < n && k < 300) begin
         @(posedge clk);
         #1 k++;
      end
      chk(name, done_q.size(), n);
   endtask

   task automatic wait_start(input string name);
      int k;
      k = 0;
      while (!bus.block_start_o && k < 100) begin
         @(posedge clk);
         #1 k++;
      end
      chk(name, bus.block_start_o, 1'b1);
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_ready"}, bus.msg_ready_o, 1'b1);
      chk({p, "_pre"},   bus.pre_data_o, 64'h0);
      chk({p, "_sel"},   bus.sel_feedback_o, 1'b0);
      chk({p, "_rv"},    bus.round_valid_o, 1'b0);
      chk({p, "_idx"},   bus.round_idx_o, 5'd0);
      chk({p, "_start"}, bus.block_start_o, 1'b0);
      chk({p, "_done"},  bus.block_done_o, 1'b0);
      chk({p, "_busy"},  bus.busy_o, 1'b0);
   endtask

   task automatic chk_cap(input string p, input logic [63:0] base);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s_beat%0d", p, i), cap[i], base + 64'(i));
   endtask

   localparam logic [63:0] BASE_A = 64'hCAFE_F00D_0000_0000;
   localparam logic [63:0] BASE_B = 64'h1234_5678_9ABC_DE00;

   initial begin
      int c, nd;
      bus.clear_i      = 1'b0;
      bus.msg_valid_i  = 1'b0;
      bus.msg_data_i   = '0;
      bus.core_ready_i = 1'b1;
      #2 chk_reset("rst0");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Contiguous fill: accept clocked at end of cycle k, buf_full seen in k+1, start in k+2.
      fill(BASE_A, 0);
      wait_done(1, "t1_done");
      repeat (4) @(posedge clk);
      #1;
      chk("t1_start_after_accept", start_q[$] - last_acc_cyc, 2);
      chk("t1_latency", done_q[$] - start_q[$], 31 + PL);
      chk_cap("t1", BASE_A);
      chk("t1_fb_rise", fb_rise, 8);
      chk("t1_rv_run", last_rv_run, 32);

      // Gapped fill while the core is not ready; extra beats offered while full.
      bus.core_ready_i = 1'b0;
      fill(BASE_A, 1);
      bus.msg_valid_i = 1'b1;
      bus.msg_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
      repeat (10) begin
         @(posedge clk);
         #1;
         chk("t2_ready_low", bus.msg_ready_o, 1'b0);
         chk("t2_idle", bus.busy_o, 1'b0);
      end
      bus.msg_valid_i  = 1'b0;
      bus.core_ready_i = 1'b1;
      c = cyc;
      wait_done(2, "t2_done");
      chk("t2_start_after_ready", start_q[$] - c, 1);
      chk_cap("t2", BASE_A);

      // Back-to-back: second block buffers during the first block's stream.
      fill(BASE_A, 0);
      fill(BASE_B, 0);
      wait_done(4, "t4_done");
      chk("t4_b2b_start", start_q[start_q.size()-1] - done_q[done_q.size()-2], 1);
      chk("t4_rv_gap", last_gap, PL);
      chk("t4_latency", done_q[$] - start_q[$], 31 + PL);
      chk_cap("t4", BASE_B);

      // Clear at stream beat 12.
      fill(BASE_B, 0);
      wait_start("t5_start");
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      bus.clear_i = 1'b1;
      @(posedge clk);
      #1 bus.clear_i = 1'b0;
      chk("t5_rv_cleared", bus.round_valid_o, 1'b0);
      chk("t5_ready", bus.msg_ready_o, 1'b1);
      chk("t5_idle", bus.busy_o, 1'b0);
      nd = done_q.size();
      repeat (60) @(posedge clk);
      #1 chk("t5_no_done", done_q.size(), nd);

      // Asynchronous reset in the first DRAIN cycle, then a fresh block.
      fill(BASE_A, 0);
      wait_start("t6_start");
      repeat (32) begin
         @(posedge clk);
         #1;
      end
      chk("t6_in_drain", bus.sel_feedback_o, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_reset("rst_drain");
      nd = done_q.size();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1 chk("t6_no_partial_done", done_q.size(), nd);
      fill(BASE_B, 0);
      wait_done(nd + 1, "t6_done");
      chk("t6_latency", done_q[$] - start_q[$], 31 + PL);
      chk_cap("t6", BASE_B);

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
